// File: rtl/req_fifo_wr_arbiter_pkg.sv
// bridge_fifo_pkg: arbiter state type, Gray/binary pointer helpers and pointer-size check
package bridge_fifo_pkg;
  typedef enum logic {ARB, LOCKED} arb_state_e;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  // Prefix XOR from the MSB down, done with doubling shifts.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s = s << 1) b = b ^ (b >> s);
    return b;
  endfunction
  // The full compare flips the top two Gray bits, so at least three pointer bits are needed.
  function automatic bit ptr_size_ok(input int f_depth, input int p_size);
    return f_depth >= 4 && (f_depth & (f_depth - 1)) == 0 && p_size == $clog2(f_depth) + 1;
  endfunction
endpackage

// File: rtl/req_fifo_wr_arbiter_if.sv
// req_fifo_wr_arbiter_if: requester handshake and FIFO write-port signals of the request FIFO arbiter
interface req_fifo_wr_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int SIZE_src2sink = 66,
  parameter int P_SIZE = 4
);
  localparam int GW = $clog2(N_REQ);
  logic [N_REQ-1:0]                    i_req_valid;
  logic [N_REQ-1:0]                    i_req_lock;
  logic [N_REQ-1:0][SIZE_src2sink-1:0] i_req_data;
  logic [N_REQ-1:0]                    o_req_ready;
  logic [GW-1:0]                       o_grant_id;
  logic                                o_fifo_wr_en;
  logic [P_SIZE-2:0]                   o_fifo_wr_addr;
  logic [SIZE_src2sink-1:0]            o_fifo_wr_data;
  logic [P_SIZE-1:0]                   o_req_gray_w_ptr;
  logic [P_SIZE-1:0]                   i_req_gray_rd_ptr_sync;
  logic                                o_fifo_full;
  logic [P_SIZE-1:0]                   o_fifo_level;
  modport master (
    output i_req_valid, i_req_lock, i_req_data, i_req_gray_rd_ptr_sync,
    input  o_req_ready, o_grant_id, o_fifo_wr_en, o_fifo_wr_addr, o_fifo_wr_data,
    input  o_req_gray_w_ptr, o_fifo_full, o_fifo_level
  );
  modport slave (
    input  i_req_valid, i_req_lock, i_req_data, i_req_gray_rd_ptr_sync,
    output o_req_ready, o_grant_id, o_fifo_wr_en, o_fifo_wr_addr, o_fifo_wr_data,
    output o_req_gray_w_ptr, o_fifo_full, o_fifo_level
  );
endinterface

// File: rtl/req_fifo_wr_arbiter_rr_arbiter.sv
// rr_arbiter: first set request at or after ptr, wrapping; with ARB_FIXED_PRIO_EN a lowest-index priority encoder
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int GW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
`ifndef ARB_FIXED_PRIO_EN
  input  logic [GW-1:0]    ptr,
`endif
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [GW-1:0]    idx,
  output logic             any
);
  logic [GW-1:0] base;
  logic [GW-1:0] j;
`ifdef ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  assign base = ptr;
`endif
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = GW'((int'(base) + k) % N_REQ);
      if (en && !any && req[j]) begin
        grant[j] = 1'b1;
        idx = j;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/req_fifo_wr_arbiter.sv
// req_fifo_wr_arbiter: arbitrates requesters onto the request FIFO write port and owns the write pointers.
// Define ARB_FIXED_PRIO_EN for lowest-index fixed priority instead of round-robin in the ARB state.
module req_fifo_wr_arbiter
  import bridge_fifo_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int SIZE_src2sink = 66,
  parameter int F_DEPTH = 8,
  parameter int P_SIZE = 4
) (
  input logic                  i_clk,
  input logic                  i_rstn,
  req_fifo_wr_arbiter_if.slave bus
);
  localparam int GW = $clog2(N_REQ);
  if (!ptr_size_ok(F_DEPTH, P_SIZE)) begin : g_bad_ptr
    $error("P_SIZE must equal $clog2(F_DEPTH)+1 with F_DEPTH a power of two >= 4");
  end
  arb_state_e        state, nxt_state;
  logic [GW-1:0]     owner, last_grant, winner, arb_idx;
  logic [N_REQ-1:0]  arb_grant, sel;
  logic              arb_any, xfer, win_lock;
  logic [P_SIZE-1:0] wbin, wbin_nxt, gray_w, rd, rd_bin;
`ifndef ARB_FIXED_PRIO_EN
  logic [GW-1:0]     rr_ptr;
`endif
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (bus.i_req_valid),
`ifndef ARB_FIXED_PRIO_EN
    .ptr   (rr_ptr),
`endif
    .en    (state == ARB),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );
  assign rd       = bus.i_req_gray_rd_ptr_sync;
  assign rd_bin   = P_SIZE'(gray2bin(32'(rd)));
  assign wbin_nxt = wbin + 1'b1;
  // With no valid requester in ARB the grant index keeps showing the previous winner.
  assign winner   = state == LOCKED ? owner : arb_any ? arb_idx : last_grant;
  assign sel      = state == LOCKED ? N_REQ'(1) << owner : arb_grant;
  assign win_lock = bus.i_req_lock[winner];
  assign bus.o_fifo_full  = P_SIZE'(bin2gray(32'(wbin))) == {~rd[P_SIZE-1:P_SIZE-2], rd[P_SIZE-3:0]};
  assign bus.o_fifo_level = wbin - rd_bin;
  assign bus.o_req_ready  = sel & {N_REQ{~bus.o_fifo_full}};
  assign xfer             = |(bus.i_req_valid & bus.o_req_ready);
  assign bus.o_fifo_wr_en     = xfer;
  assign bus.o_fifo_wr_addr   = wbin[P_SIZE-2:0];
  assign bus.o_fifo_wr_data   = bus.i_req_data[winner];
  assign bus.o_grant_id       = winner;
  assign bus.o_req_gray_w_ptr = gray_w;
  always_comb begin
    nxt_state = state;
    nxt_state = state == ARB ? (xfer && win_lock ? LOCKED : ARB)
              : (!win_lock && (xfer || !bus.i_req_valid[owner]) ? ARB : LOCKED);
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= ARB;
      owner <= '0;
      last_grant <= '0;
      wbin <= '0;
      gray_w <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr <= '0;
`endif
    end else begin
      state <= nxt_state;
      last_grant <= winner;
      if (xfer) begin
        wbin <= wbin_nxt;
        gray_w <= P_SIZE'(bin2gray(32'(wbin_nxt)));
        if (state == ARB) owner <= winner;
`ifndef ARB_FIXED_PRIO_EN
        rr_ptr <= winner == GW'(N_REQ - 1) ? '0 : winner + 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_req_fifo_wr_arbiter.sv
// tb_req_fifo_wr_arbiter: directed stimulus with a write scoreboard for req_fifo_wr_arbiter
module tb_req_fifo_wr_arbiter;
  localparam int N = 2, W = 66, FD = 8, PS = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  req_fifo_wr_arbiter_if #(.N_REQ(N), .SIZE_src2sink(W), .P_SIZE(PS)) bus ();
  req_fifo_wr_arbiter #(.N_REQ(N), .SIZE_src2sink(W), .F_DEPTH(FD), .P_SIZE(PS)) dut (
    .i_clk  (clk),
    .i_rstn (rst_n),
    .bus    (bus)
  );

  typedef struct {logic [W-1:0] d; logic l;} ent_t;
  typedef struct {int g; int a; logic [W-1:0] d;} exp_t;
  ent_t rq[N][$];
  exp_t eq[$];
  int checks = 0, errors = 0, wr_total = 0;
  logic [N-1:0] mask = '1, hold = '0;
  bit track = 0;

  function automatic logic [W-1:0] dval(input int r, input int n);
    return {2'(r), 32'hC0DE_0000 + 32'(n), 32'(n * 13 + r)};
  endfunction
  function automatic logic [PS-1:0] gray(input int b);
    logic [PS-1:0] x;
    x = PS'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask
  task automatic enq(input int r, input int n, input logic l);
    rq[r].push_back('{dval(r, n), l});
  endtask
  task automatic exp_wr(input int g, input int a, input int r, input int n);
    eq.push_back('{g, a, dval(r, n)});
  endtask
  task automatic apply();
    for (int r = 0; r < N; r++) begin
      bus.i_req_valid[r] = mask[r] && rq[r].size() > 0;
      bus.i_req_data[r]  = rq[r].size() > 0 ? rq[r][0].d : '0;
      bus.i_req_lock[r]  = rq[r].size() > 0 ? rq[r][0].l : hold[r];
    end
  endtask
  task automatic sync();
    @(posedge clk);
    #1;
  endtask
  task automatic step();
    logic [N-1:0] fire;
    @(negedge clk);
    fire = bus.i_req_valid & bus.o_req_ready;
    sync();
    for (int r = 0; r < N; r++)
      if (fire[r]) begin
        void'(rq[r].pop_front());
        wr_total++;
      end
    if (track) bus.i_req_gray_rd_ptr_sync = gray(wr_total);
    apply();
  endtask
  task automatic drain(input int max);
    int n;
    n = 0;
    while ((rq[0].size() > 0 || rq[1].size() > 0) && n < max) begin
      step();
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries left after %0d cycles, want 0", rq[0].size() + rq[1].size(), n);
    end
  endtask
  task automatic chk_zero(input string tag);
    @(negedge clk);
    chk({tag, "_ready"}, bus.o_req_ready, 0);
    chk({tag, "_wr_en"}, bus.o_fifo_wr_en, 0);
    chk({tag, "_grant"}, bus.o_grant_id, 0);
    chk({tag, "_full"}, bus.o_fifo_full, 0);
    chk({tag, "_level"}, bus.o_fifo_level, 0);
    chk({tag, "_gray"}, bus.o_req_gray_w_ptr, 4'b0000);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (bus.o_fifo_wr_en) begin
        if (eq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d grant %0d with nothing expected", bus.o_fifo_wr_addr, bus.o_grant_id);
        end else begin
          e = eq.pop_front();
          chk("wr_grant", bus.o_grant_id, e.g);
          chk("wr_addr", bus.o_fifo_wr_addr, e.a);
          chk("wr_data", bus.o_fifo_wr_data, e.d);
        end
      end
      if (track) chk("no_false_full", bus.o_fifo_full, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_req_valid = '0;
    bus.i_req_lock = '0;
    bus.i_req_data = '0;
    bus.i_req_gray_rd_ptr_sync = '0;
    repeat (2) @(posedge clk);
    chk_zero("rst");
    sync();
    rst_n = 1'b1;
    // Round-robin across both requesters.
    enq(0, 0, 0); enq(0, 1, 0); enq(1, 0, 0); enq(1, 1, 0);
`ifdef ARB_FIXED_PRIO_EN
    exp_wr(0, 0, 0, 0); exp_wr(0, 1, 0, 1); exp_wr(1, 2, 1, 0); exp_wr(1, 3, 1, 1);
`else
    exp_wr(0, 0, 0, 0); exp_wr(1, 1, 1, 0); exp_wr(0, 2, 0, 1); exp_wr(1, 3, 1, 1);
`endif
    apply();
    drain(20);
    @(negedge clk);
    chk("rr_level", bus.o_fifo_level, 4);
    chk("rr_gray", bus.o_req_gray_w_ptr, 4'b0110);
    chk("rr_full", bus.o_fifo_full, 0);
    // Fill to full, then release one slot through the read pointer.
    sync();
    for (int n = 2; n < 6; n++) begin
      enq(0, n, 0);
      exp_wr(0, n + 2, 0, n);
    end
    apply();
    drain(20);
    @(negedge clk);
    chk("full_set", bus.o_fifo_full, 1);
    chk("full_level", bus.o_fifo_level, 8);
    chk("full_gray", bus.o_req_gray_w_ptr, 4'b1100);
    sync();
    enq(0, 6, 0);
    exp_wr(0, 0, 0, 6);
    apply();
    @(negedge clk);
    chk("full_ready", bus.o_req_ready, 2'b00);
    @(negedge clk);
    chk("full_ready2", bus.o_req_ready, 2'b00);
    chk("full_hold", bus.o_fifo_full, 1);
    sync();
    bus.i_req_gray_rd_ptr_sync = 4'b0001;
    @(negedge clk);
    chk("unfull", bus.o_fifo_full, 0);
    chk("unfull_level", bus.o_fifo_level, 7);
    chk("unfull_ready", bus.o_req_ready, 2'b01);
    sync();
    void'(rq[0].pop_front());
    apply();
    @(negedge clk);
    chk("refull", bus.o_fifo_full, 1);
    chk("refull_level", bus.o_fifo_level, 8);
    // Reset in the middle of a full FIFO.
    sync();
    rq[0].delete();
    rq[1].delete();
    apply();
    bus.i_req_gray_rd_ptr_sync = '0;
    rst_n = 1'b0;
    chk_zero("midrst");
    sync();
    rst_n = 1'b1;
    // Locked sequence from requester 1 while requester 0 waits.
    mask = 2'b10;
    enq(1, 0, 1); enq(1, 1, 1); enq(1, 2, 0); enq(0, 0, 0); enq(0, 1, 0);
    exp_wr(1, 0, 1, 0); exp_wr(1, 1, 1, 1); exp_wr(1, 2, 1, 2); exp_wr(0, 3, 0, 0); exp_wr(0, 4, 0, 1);
    apply();
    step();
    mask = 2'b11;
    apply();
    #1;
    chk("lock_excl_ready", bus.o_req_ready, 2'b10);
    drain(20);
    @(negedge clk);
    chk("lock_level", bus.o_fifo_level, 5);
    // Reset while locked drops ownership.
    sync();
    mask = 2'b10;
    hold = 2'b10;
    enq(1, 3, 1);
    exp_wr(1, 5, 1, 3);
    apply();
    step();
    #1;
    chk("locked_idle_ready", bus.o_req_ready, 2'b10);
    rst_n = 1'b0;
    chk_zero("lockrst");
    sync();
    rst_n = 1'b1;
    mask = 2'b11;
    enq(0, 2, 0);
    exp_wr(0, 0, 0, 2);
    apply();
    drain(10);
    hold = '0;
    apply();
    // Wrap the pointers with the reader keeping pace.
    sync();
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
    wr_total = 0;
    track = 1;
    bus.i_req_gray_rd_ptr_sync = '0;
    for (int i = 0; i < 20; i++) begin
      enq(0, 10 + i, 0);
      exp_wr(0, i % 8, 0, 10 + i);
    end
    apply();
    drain(60);
    track = 0;
    @(negedge clk);
    chk("wrap_level", bus.o_fifo_level, 0);
    chk("wrap_gray", bus.o_req_gray_w_ptr, gray(20));
`ifdef ARB_FIXED_PRIO_EN
    sync();
    enq(0, 40, 0); enq(0, 41, 0); enq(0, 42, 0); enq(1, 40, 0);
    exp_wr(0, 4, 0, 40); exp_wr(0, 5, 0, 41); exp_wr(0, 6, 0, 42); exp_wr(1, 7, 1, 40);
    apply();
    drain(20);
`endif
    repeat (3) sync();
    chk("exp_queue_empty", eq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/req_fifo_wr_arbiter.md
Name: req_fifo_wr_arbiter

Overview:
Source-domain write-side controller for the bridge request FIFO. It round-robin arbitrates N_REQ requesters, each an AHB-side command packer, onto the single request FIFO write port, and supports locked (atomic) sequences. It owns the binary and Gray write pointers and computes full and level against the synchronized Gray read pointer. It sits in the i_clk_src domain, directly ahead of the FIFO memory and the pointer synchronizers.

Parameters:
N_REQ, 2, number of requesters (≥2)
SIZE_src2sink, 66, request entry width in bits
F_DEPTH, 8, FIFO entries (power of two)
P_SIZE, 4, pointer width; must equal $clog2(F_DEPTH)+1

Ports:
i_clk  in  1  source-domain clock
i_rstn  in  1  asynchronous active-low reset
i_req_valid  in  N_REQ  per-requester entry valid
i_req_lock  in  N_REQ  per-requester lock; holds the grant across entries
i_req_data  in  N_REQ x SIZE_src2sink  per-requester entry payload
o_req_ready  out  N_REQ  per-requester accept
o_grant_id  out  $clog2(N_REQ)  current winner or owner index
o_fifo_wr_en  out  1  FIFO memory write strobe
o_fifo_wr_addr  out  P_SIZE-1  FIFO memory write address
o_fifo_wr_data  out  SIZE_src2sink  FIFO memory write data
o_req_gray_w_ptr  out  P_SIZE  Gray write pointer, registered, to the synchronizer
i_req_gray_rd_ptr_sync  in  P_SIZE  Gray read pointer already synchronized into i_clk
o_fifo_full  out  1  FIFO full
o_fifo_level  out  P_SIZE  occupied entries, 0..F_DEPTH

Behaviour:
- Clocking and reset: single clock i_clk; asynchronous active-low reset i_rstn.
- Reset values:
  - binary and Gray write pointers = 0
  - state = ARB, RR pointer = 0, owner = 0
  - o_req_gray_w_ptr = 0, o_grant_id = 0, o_fifo_full = 0, o_fifo_level = 0
  - all ready and write-enable outputs = 0
- Handshake: a transfer occurs when i_req_valid[i] & o_req_ready[i]. Ready is combinational: o_req_ready[i] = (i == winner) & ~o_fifo_full. The transfer writes in the same cycle (zero latency):
  - o_fifo_wr_en = 1
  - o_fifo_wr_addr = wbin[P_SIZE-2:0]
  - o_fifo_wr_data = i_req_data[winner]
  - o_fifo_wr_en = (transfer occurred); wr_addr and wr_data are don't-care when wr_en = 0.
- Requester rule: once valid, a requester holds its data stable until ready.
- FSM state ARB:
  - Winner = first valid requester searching from the RR pointer, wrapping.
  - On each transfer, RR pointer ← winner+1 mod N_REQ.
  - If i_req_lock[winner] = 1 at the transfer, go to LOCKED with owner = winner.
  - No valid requester: o_grant_id holds its last value and there is no write.
- FSM state LOCKED:
  - Winner = owner; every other requester's ready = 0.
  - Return to ARB when either (a) the owner transfers with lock = 0, or (b) the owner has valid = 0 and lock = 0.
  - The RR pointer still advances past the owner on each owner transfer.
- Pointers:
  - wbin += 1 on each transfer, wrapping mod 2^P_SIZE.
  - o_req_gray_w_ptr is registered: it equals gray(wbin) one cycle after the increment.
  - Full and level are combinational from registered wbin and the current i_req_gray_rd_ptr_sync.
- Full: o_fifo_full = (gray(wbin) == {~rd[P_SIZE-1:P_SIZE-2], rd[P_SIZE-3:0]}).
- Level: o_fifo_level = wbin − gray2bin(rd_sync), mod 2^P_SIZE.
- Full boundary: while full, no requester sees ready. Full clears the cycle after the synchronized read pointer moves.
- Simultaneous events: a write and a read-pointer change in the same cycle are both reflected in next-cycle full and level.
- Reset mid-operation: everything returns to the reset values immediately. This includes a LOCKED sequence in progress, which is dropped.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: the ARB state uses fixed priority, lowest index wins, and the RR pointer is not implemented. Lock behaviour is unchanged.
- Undefined: round-robin as specified above.

Decomposition:
- Package bridge_fifo_pkg holds:
  - the arb_state_e typedef {ARB, LOCKED}
  - the bin2gray and gray2bin functions
  - the P_SIZE/F_DEPTH consistency check as an elaboration-time assertion
- One sub-module is natural: rr_arbiter (request vector, RR pointer, enable → one-hot grant and index). In ARB_FIXED_PRIO_EN builds it degenerates to a priority encoder.

Test Plan:
- Reset: assert i_rstn = 0 mid-run → all outputs 0, Gray pointer 4'b0000, state ARB. After release, the first write goes to addr 0.
- Round-robin: both requesters valid for 4 transfers, rd_sync = 0 → grant order 0,1,0,1; o_fifo_level = 4; o_req_gray_w_ptr = 4'b0110.
- Full: hold rd_sync = 0 and push 8 entries → after the 8th, o_fifo_full = 1, ready = 2'b00, Gray pointer 4'b1100. Set rd_sync = 4'b0001 → full clears next cycle, level = 7.
- Wrap: cycle 20 entries through with rd_sync tracking → wr_addr sequence 0..7,0..7,0..3; full never falsely asserted.
- Lock: requester 1 issues 3 entries with lock = 1, 1, 0 while requester 0 is continuously valid → grants 1,1,1 then 0.
- Fixed priority (ARB_FIXED_PRIO_EN): both requesters valid for 3 transfers → grants 0,0,0.
